// File: rtl/csa_mult_pkg.sv
// Shared types and sizing for the iterative carry-save multiplier.
package csa_mult_pkg;

  localparam int MULT_N = 16;
  localparam int CNT_W  = $clog2(MULT_N);
  localparam int PROD_W = 2 * MULT_N;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCUM   = 2'd1,
    ST_RESOLVE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  // Bit index width for an n-bit operand; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/csa_seq_mult_csa.sv
// Bitwise 3:2 carry-save compressor. The carry out of the top bit is dropped,
// so only the lower WIDTH-1 majority bits are ever formed.
module csa_seq_mult_csa #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] z,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] c
);

  logic [WIDTH-2:0] maj;

  assign s   = x ^ y ^ z;
  assign maj = (x[WIDTH-2:0] & y[WIDTH-2:0]) |
               (x[WIDTH-2:0] & z[WIDTH-2:0]) |
               (y[WIDTH-2:0] & z[WIDTH-2:0]);
  assign c   = {maj, 1'b0};

endmodule

// File: rtl/csa_seq_mult.sv
// Iterative unsigned N x N multiplier: one partial product per cycle is folded
// into a redundant sum/carry pair, then a single carry-propagate add resolves it.
//
// state   | meaning
// IDLE    | waiting for operands, in_ready high
// ACCUM   | N cycles of partial-product accumulation through the CSA
// RESOLVE | one cycle: p <= S + C, raise out_valid
// HOLD    | product presented until out_ready handshake
module csa_seq_mult
  import csa_mult_pkg::*;
#(
  parameter int N = MULT_N
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  input  logic           clear,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] p
);

  localparam int PW = 2 * N;
  localparam int CW = cnt_width(N);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [PW-1:0]   s_q, s_d;
  logic [PW-1:0]   c_q, c_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   p_q, p_d;
  logic            out_valid_q, out_valid_d;

  logic [PW-1:0]   pp;
  logic [PW-1:0]   csa_s;
  logic [PW-1:0]   csa_c;

  // Partial product for the current multiplier bit.
  always_comb begin
    pp = '0;
    if (b_q[cnt_q]) pp = PW'(a_q) << cnt_q;
  end

  csa_seq_mult_csa #(.WIDTH(PW)) u_csa (
    .x (s_q),
    .y (c_q),
    .z (pp),
    .s (csa_s),
    .c (csa_c)
  );

  // Next-state and datapath update; clear overrides every other transition.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    c_d         = c_q;
    cnt_d       = cnt_q;
    p_d         = p_q;
    out_valid_d = out_valid_q;
    if (clear) begin
      state_d     = ST_IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid) begin
            a_d     = a;
            b_d     = b;
            s_d     = '0;
            c_d     = '0;
            cnt_d   = '0;
            state_d = ST_ACCUM;
          end
        end
        ST_ACCUM: begin
          s_d   = csa_s;
          c_d   = csa_c;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = ST_RESOLVE;
        end
        ST_RESOLVE: begin
          p_d         = s_q + c_q;
          out_valid_d = 1'b1;
          state_d     = ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      c_q         <= '0;
      cnt_q       <= '0;
      p_q         <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      c_q         <= c_d;
      cnt_q       <= cnt_d;
      p_q         <= p_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_ACCUM) || (state_q == ST_RESOLVE);
  assign out_valid = out_valid_q;
  assign p         = p_q;

endmodule

// File: tb/tb_csa_seq_mult.sv
// Bench for csa_seq_mult: a job-level model predicts in_ready/busy/out_valid/p
// every cycle from acceptance time and a*b; directed tests pin literal values.
module tb_csa_seq_mult;

  localparam int N = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           clear = 1'b0;
  logic           out_ready = 1'b0;
  logic [N-1:0]   a = '0;
  logic [N-1:0]   b = '0;
  logic           in_ready;
  logic           busy;
  logic           out_valid;
  logic [2*N-1:0] p;

  csa_seq_mult #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .clear     (clear),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int ecnt = 0;

  bit          has_job = 1'b0;
  int          acc_edge = 0;
  logic [31:0] exp_p = '0;
  logic [31:0] last_p = '0;
  int          n_hs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) ecnt <= ecnt + 1;

  // Job-level model: one job at a time; result appears N+1 edges after acceptance.
  always @(negedge clk) begin : monitor
    bit ov_e;
    bit busy_e;
    if (rst) begin
      has_job = 1'b0;
      last_p  = '0;
    end
    ov_e   = has_job && (ecnt >= acc_edge + N + 1);
    busy_e = has_job && !ov_e;
    if (ov_e) last_p = exp_p;
    chk("mon_in_ready", in_ready, !has_job);
    chk("mon_busy", busy, busy_e);
    chk("mon_out_valid", out_valid, ov_e);
    chk("mon_p", p, last_p);
    if (!rst) begin
      if (clear) begin
        has_job = 1'b0;
      end else if (ov_e && out_ready) begin
        has_job = 1'b0;
        n_hs++;
      end else if (!has_job && in_valid) begin
        has_job  = 1'b1;
        acc_edge = ecnt + 1;
        exp_p    = 32'(a) * 32'(b);
      end
    end
  end

  task automatic mult_one(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic [31:0] ep, input bit complete);
    int lat;
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 16'hDEAD;
    b = 16'hBEEF;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, N + 1);
    chk("product", p, ep);
    if (complete) begin
      @(posedge clk); #1;
      chk("post_hs_out_valid", out_valid, 0);
      chk("post_hs_in_ready", in_ready, 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int waitc;
    bit rdy;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_p", p, 0);

    out_ready = 1'b1;
    mult_one(16'd3, 16'd5, 32'd15, 1'b1);
    mult_one(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b1);
    mult_one(16'h1234, 16'h0000, 32'h0, 1'b1);

    out_ready = 1'b0;
    mult_one(16'h00FF, 16'h0101, 32'h0000FFFF, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      a = 16'd1;
      b = 16'd1;
      @(posedge clk); #1;
      chk("stall_p", p, 32'h0000FFFF);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_hs_out_valid", out_valid, 0);
    chk("bp_hs_in_ready", in_ready, 1);

    a = 16'h00AB;
    b = 16'h00CD;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_in_ready", in_ready, 1);
    chk("clr_busy", busy, 0);
    chk("clr_out_valid", out_valid, 0);
    repeat (20) @(posedge clk);
    #1 chk("clr_no_result", out_valid, 0);

    clear = 1'b1;
    in_valid = 1'b1;
    a = 16'd11;
    b = 16'd13;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    chk("idle_clr_in_ready", in_ready, 1);
    chk("idle_clr_busy", busy, 0);

    mult_one(16'd7, 16'd9, 32'd63, 1'b1);

    a = 16'h5555;
    b = 16'h3333;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_p", p, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("arst_in_ready", in_ready, 1);

    for (int i = 0; i < 100; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      if (i % 17 == 3) a = '0;
      if (i % 23 == 5) b = 16'hFFFF;
      in_valid = 1'b1;
      waitc = 0;
      rdy = 1'b0;
      while (!rdy && waitc < 200) begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk); #1;
        out_ready = 1'($urandom_range(0, 1));
        waitc++;
      end
      if (!rdy) chk("stream_accept", rdy, 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (N + 6) @(posedge clk);
    #1 chk("drain_in_ready", in_ready, 1);
    chk("handshake_count", n_hs, 105);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/csa_seq_mult.md
Name: csa_seq_mult

Overview:
- Iterative unsigned N x N multiplier controller that drives the team's carry-save adder (CSA) as its accumulation datapath.
- Each cycle, one partial product is folded into a redundant sum/carry pair. A single carry-propagate add then resolves the pair into the 2N-bit product.
- Sits in front of the Barrett reduction stages as the shared multiply engine.
- Uses a valid/ready handshake on both the input and output sides.

Parameters:
- N, 16, operand width in bits; N >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operands a/b are valid
- in_ready  out  1  block can accept operands; high only in IDLE
- a  in  N  multiplicand, unsigned
- b  in  N  multiplier, unsigned
- clear  in  1  synchronous abort; returns to IDLE with no result
- busy  out  1  high in ACCUM or RESOLVE
- out_valid  out  1  product p is valid
- out_ready  in  1  consumer accepts p
- p  out  2N  product a*b

Behaviour:
- Reset values:
  - State is IDLE.
  - out_valid=0, busy=0, p=0.
  - Internal S=0, C=0, count=0.
  - in_ready=1, because it is decoded from state.
- Reset asserted mid-operation discards all work. No out_valid pulse is produced.
- FSM states: IDLE, ACCUM, RESOLVE, HOLD.
- IDLE:
  - On an edge with in_valid=1: latch a_reg=a and b_reg=b; clear S, C and count; go to ACCUM.
  - If in_valid=0, stay in IDLE.
- ACCUM (exactly N edges):
  - Partial product pp = b_reg[count] ? (zero-extended a_reg << count) : 0, 2N bits wide.
  - {S,C} <= CSA(S, C, pp) at width 2N.
  - CSA semantics:
    - S = X^Y^Z bitwise.
    - C = majority carries shifted left by 1 with bit 0 = 0; the carry out of bit 2N-1 is discarded.
    - Because a*b < 2^(2N), the discard is harmless.
  - count increments. After the iteration with count=N-1, go to RESOLVE.
- RESOLVE: one edge; p <= (S + C) mod 2^(2N); out_valid <= 1; go to HOLD.
- HOLD:
  - out_valid stays high and p is held stable until out_valid & out_ready on an edge.
  - On that edge: out_valid <= 0, go to IDLE.
  - p keeps its last value after the handshake.
- Latency and throughput:
  - out_valid rises on the (N+1)th rising edge after the accepting edge.
  - With out_ready held high, a new operand can be accepted at the earliest 2 edges after out_valid rises.
  - Throughput is one product per N+3 cycles.
- in_ready=1 only in IDLE. in_valid in any other state is ignored; operands are not queued.
- out_ready outside HOLD is ignored.
- clear:
  - In ACCUM, RESOLVE or HOLD, clear forces IDLE on the next edge and drops out_valid to 0.
  - clear has priority over all other transitions, including a simultaneous out handshake.
  - clear in IDLE has priority over in_valid: the operands are not accepted.
- Operands a and b may change freely after acceptance; only a_reg and b_reg are used.
- Boundary cases:
  - a=0 or b=0 gives p=0 with the same fixed latency. There is no early termination.
  - a=b=2^N-1 gives p=2^(2N)-2^(N+1)+1.

Decomposition:
- Shared package csa_mult_pkg contains:
  - The state enum typedef (IDLE/ACCUM/RESOLVE/HOLD).
  - The count width constant, $clog2(N).
  - The product width constant, 2N.
- One sub-module: the team's existing CSA, instantiated once at n=2N.
- The final carry-propagate adder and the partial-product mux are inline in csa_seq_mult.

Test Plan:
1. Basic multiply (N=16): a=3, b=5, out_ready=1 -> out_valid high 17 edges after acceptance, p=15, then IDLE with in_ready=1.
2. Maximum operands: a=0xFFFF, b=0xFFFF -> p=0xFFFE0001. Also a=0x1234, b=0 -> p=0 with identical latency.
3. Output backpressure: a=0x00FF, b=0x0101, out_ready=0 for 10 cycles -> p=0x00FFFF held stable and in_ready=0 throughout; in_valid pulses during the stall are ignored; the handshake completes in the cycle out_ready rises.
4. Abort: clear asserted at ACCUM count=7 -> IDLE next edge, no out_valid. The next operands a=7, b=9 give p=63.
5. Asynchronous reset: rst asserted mid-ACCUM -> out_valid, busy and p are 0 immediately without a clock edge; in_ready=1 after release.
6. Back-to-back stream: 100 random pairs with random out_ready stalls -> every p matches a*b in order; none dropped or duplicated.
